// File: rtl/seq_muldiv_pkg.sv
// Shared types and constants for the sequential 4-bit multiply/divide unit.
// Imported by seq_muldiv and by anything that decodes its op field.
package seq_muldiv_pkg;

   localparam int WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } op_t;

   localparam logic [2*WIDTH-1:0] DIV_ZERO_RESULT = 8'hFF;

endpackage

// File: rtl/seq_muldiv.sv
// Sequential unsigned 4x4 multiplier (shift-add) and 4/4 divider (restoring)
// sharing one hi/lo shift register; one iteration per clock, registered outputs.
module seq_muldiv
   import seq_muldiv_pkg::*;
#(
   parameter int ITER = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   op,
   input  logic [WIDTH-1:0]       a,
   input  logic [WIDTH-1:0]       b,
   output logic                   busy,
   output logic                   done,
   output logic [2*WIDTH-1:0]     result,
   output logic                   div_zero
);

   localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

   state_t             r_state;
   op_t                r_op;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH:0]     r_hi;   // upper partial product / partial remainder
   logic [WIDTH-1:0]   r_lo;   // multiplier bits / dividend-then-quotient bits

   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_shl;
   logic [WIDTH+1:0]   w_trial;
   logic [WIDTH:0]     w_hi_nxt;
   logic [WIDTH-1:0]   w_lo_nxt;
   logic [2*WIDTH-1:0] w_result_nxt;

   // One iteration of whichever algorithm is selected.
   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      w_sum    = '0;
      w_shl    = '0;
      w_trial  = '0;
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      if (r_op == OP_MUL) begin
         // r_hi never exceeds 15 after a shift, so the add cannot overflow 5 bits.
         w_sum    = r_hi + (r_lo[0] ? {1'b0, r_a} : '0);
         w_hi_nxt = {1'b0, w_sum[WIDTH:1]};
         w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
      end else begin
         w_shl   = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
         w_trial = {1'b0, w_shl} - {2'b00, r_b};
         if (w_trial[WIDTH+1]) begin
            w_hi_nxt = w_shl;
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
         end else begin
            w_hi_nxt = w_trial[WIDTH:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
         end
      end
   end

   // Product is {hi[3:0], lo}; division yields {remainder, quotient} in the same slots.
   assign w_result_nxt = {w_hi_nxt[WIDTH-1:0], w_lo_nxt};

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_op     <= OP_MUL;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         div_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if ((op_t'(op) == OP_DIV) && (b == '0)) begin
                     r_state  <= DONE;
                     done     <= 1'b1;
                     result   <= DIV_ZERO_RESULT;
                     div_zero <= 1'b1;
                  end else begin
                     r_state <= RUN;
                     r_op    <= op_t'(op);
                     r_a     <= a;
                     r_b     <= b;
                     r_cnt   <= '0;
                     r_hi    <= '0;
                     r_lo    <= (op_t'(op) == OP_DIV) ? a : b;
                  end
               end
            end
            RUN: begin
               r_hi  <= w_hi_nxt;
               r_lo  <= w_lo_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  // Last iteration: publish the result so it is valid during DONE.
                  r_state  <= DONE;
                  done     <= 1'b1;
                  result   <= w_result_nxt;
                  div_zero <= 1'b0;
               end
            end
            DONE: begin
               r_state <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed self-checking bench for seq_muldiv: latency, results, divide-by-zero,
// back-to-back issue, mid-run reset and operand isolation.
module tb_seq_muldiv;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       op;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       div_zero;

   int checks = 0;
   int errors = 0;

   seq_muldiv #(.ITER(4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse start for one edge (edge k); returns at the negedge of cycle k+1.
   task automatic issue(input logic t_op, input logic [3:0] t_a, input logic [3:0] t_b);
      @(negedge clk);
      op    = t_op;
      a     = t_a;
      b     = t_b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({busy, done, result, div_zero} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b result=%h div_zero=%b, expected all 0",
                  busy, done, result, div_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
      end
   endtask

   task automatic test_mul_max();
      issue(1'b0, 4'd15, 4'd15);
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) @(negedge clk);
         checks++;
         if (busy !== 1'(c <= 5) || done !== 1'(c == 5)) begin
            errors++;
            $display("FAIL mul_max_timing c=%0d: got busy=%b done=%b, expected busy=%b done=%b",
                     c, busy, done, c <= 5, c == 5);
         end
         if (c == 5) begin
            checks++;
            if (result !== 8'hE1 || div_zero !== 1'b0) begin
               errors++;
               $display("FAIL mul_max_result: got %h dz=%b, expected e1 dz=0", result, div_zero);
            end
         end
      end
   endtask

   task automatic test_div();
      issue(1'b1, 4'd13, 4'd4);
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) @(negedge clk);
         checks++;
         if (done !== 1'(c == 5)) begin
            errors++;
            $display("FAIL div_timing c=%0d: got done=%b, expected %b", c, done, c == 5);
         end
         if (c == 5) begin
            checks++;
            if (result !== 8'h13 || div_zero !== 1'b0) begin
               errors++;
               $display("FAIL div_result: got %h dz=%b, expected 13 dz=0", result, div_zero);
            end
         end
      end
   endtask

   task automatic test_div_zero();
      issue(1'b1, 4'd9, 4'd0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || result !== 8'hFF || div_zero !== 1'b1) begin
         errors++;
         $display("FAIL div_zero_done: got done=%b busy=%b result=%h dz=%b, expected 1 1 ff 1",
                  done, busy, result, div_zero);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== 8'hFF || div_zero !== 1'b1) begin
         errors++;
         $display("FAIL div_zero_idle: got done=%b busy=%b result=%h dz=%b, expected 0 0 ff 1",
                  done, busy, result, div_zero);
      end
      issue(1'b0, 4'd2, 4'd3);
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) @(negedge clk);
         checks++;
         if (c < 5 && (result !== 8'hFF || div_zero !== 1'b1 || done !== 1'b0)) begin
            errors++;
            $display("FAIL div_zero_hold c=%0d: got result=%h dz=%b done=%b, expected ff 1 0",
                     c, result, div_zero, done);
         end
         if (c == 5 && (result !== 8'h06 || div_zero !== 1'b0 || done !== 1'b1)) begin
            errors++;
            $display("FAIL div_zero_clear: got result=%h dz=%b done=%b, expected 06 0 1",
                     result, div_zero, done);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n_done;
      n_done = 0;
      @(negedge clk);
      op    = 1'b0;
      a     = 4'd3;
      b     = 4'd5;
      start = 1'b1;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
         checks++;
         if (done !== 1'((c % 6) == 5) || busy !== 1'((c % 6) != 0)) begin
            errors++;
            $display("FAIL b2b_timing c=%0d: got done=%b busy=%b, expected done=%b busy=%b",
                     c, done, busy, (c % 6) == 5, (c % 6) != 0);
         end
         if ((c % 6) == 5) begin
            checks++;
            if (result !== 8'h0F) begin
               errors++;
               $display("FAIL b2b_result c=%0d: got %h, expected 0f", c, result);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (n_done != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d done pulses, expected 3", n_done);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      int n_done;
      n_done = 0;
      issue(1'b0, 4'd7, 4'd7);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, result, div_zero} !== 11'd0) begin
         errors++;
         $display("FAIL midrun_reset: got busy=%b done=%b result=%h dz=%b, expected all 0",
                  busy, done, result, div_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) n_done++;
      end
      checks++;
      if (n_done != 0) begin
         errors++;
         $display("FAIL midrun_quiet: got %0d active cycles, expected 0", n_done);
      end
      issue(1'b0, 4'd7, 4'd7);
      repeat (4) @(negedge clk);
      checks++;
      if (done !== 1'b1 || result !== 8'h31) begin
         errors++;
         $display("FAIL midrun_retry: got done=%b result=%h, expected 1 31", done, result);
      end
      @(negedge clk);
   endtask

   task automatic test_operand_change();
      issue(1'b0, 4'd0, 4'd11);
      op = 1'b1;
      a  = 4'd15;
      b  = 4'd15;
      repeat (4) @(negedge clk);
      checks++;
      if (done !== 1'b1 || result !== 8'h00 || div_zero !== 1'b0) begin
         errors++;
         $display("FAIL operand_change: got done=%b result=%h dz=%b, expected 1 00 0",
                  done, result, div_zero);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || result !== 8'h00) begin
         errors++;
         $display("FAIL operand_change_hold: got busy=%b result=%h, expected 0 00", busy, result);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      test_reset();
      test_mul_max();
      test_div();
      test_div_zero();
      test_back_to_back();
      test_reset_mid_run();
      test_operand_change();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
